// File: rtl/uart_hex_word_assembler.sv
// Parses ASCII hex digits from a UART byte stream into a DW-bit word.
// A line terminator commits the word to data_o, which feeds the seven-segment decoder.
module uart_hex_word_assembler #(
  parameter int DW = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_valid_i,
  input  logic [7:0]                    rx_data_i,
  output logic [DW-1:0]                 data_o,
  output logic                          word_valid_o,
  output logic                          err_o,
  output logic [$clog2(DW/4+1)-1:0]     digit_count_o
);

  localparam int NIBBLES = DW / 4;
  localparam int CW      = $clog2(NIBBLES + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, ERROR} state_t;

  state_t          state_reg;
  logic [DW-1:0]   shreg_reg;
  logic [DW-1:0]   data_reg;
  logic [CW-1:0]   count_reg;
  logic            word_valid_reg;
  logic            err_reg;

  logic            is_hex, is_term, is_bs, is_esc, is_space, is_other;
  logic [3:0]      nibble;

  // Letters A-F/a-f carry 1..6 in their low nibble, so adding 9 yields 10..15.
  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    if (rx_data_i >= 8'h30 && rx_data_i <= 8'h39) begin
      is_hex = 1'b1;
      nibble = rx_data_i[3:0];
    end else if ((rx_data_i >= 8'h41 && rx_data_i <= 8'h46) ||
                 (rx_data_i >= 8'h61 && rx_data_i <= 8'h66)) begin
      is_hex = 1'b1;
      nibble = rx_data_i[3:0] + 4'd9;
    end
    is_term  = (rx_data_i == 8'h0D) || (rx_data_i == 8'h0A);
    is_bs    = (rx_data_i == 8'h08);
    is_esc   = (rx_data_i == 8'h1B);
    is_space = (rx_data_i == 8'h20);
    is_other = !(is_hex || is_term || is_bs || is_esc || is_space);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      shreg_reg      <= '0;
      data_reg       <= '0;
      count_reg      <= '0;
      word_valid_reg <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      word_valid_reg <= 1'b0;
      if (rx_valid_i) begin
        case (state_reg)
          IDLE: begin
            // Terminators are ignored here so that CR LF commits only once.
            if (is_hex) begin
              shreg_reg <= {{(DW-4){1'b0}}, nibble};
              count_reg <= CW'(1);
              state_reg <= COLLECT;
            end else if (is_other) begin
              state_reg <= ERROR;
              err_reg   <= 1'b1;
            end
          end
          COLLECT: begin
            if (is_hex) begin
              shreg_reg <= {shreg_reg[DW-5:0], nibble};
              if (count_reg != CW'(NIBBLES))
                count_reg <= count_reg + CW'(1);
            end else if (is_bs) begin
              shreg_reg <= shreg_reg >> 4;
              count_reg <= count_reg - CW'(1);
              if (count_reg == CW'(1))
                state_reg <= IDLE;
            end else if (is_term) begin
              data_reg       <= shreg_reg;
              word_valid_reg <= 1'b1;
              shreg_reg      <= '0;
              count_reg      <= '0;
              state_reg      <= IDLE;
            end else if (is_esc) begin
              shreg_reg <= '0;
              count_reg <= '0;
              state_reg <= IDLE;
            end else if (is_other) begin
              shreg_reg <= '0;
              count_reg <= '0;
              state_reg <= ERROR;
              err_reg   <= 1'b1;
            end
          end
          ERROR: begin
            if (is_term || is_esc) begin
              state_reg <= IDLE;
              err_reg   <= 1'b0;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign data_o        = data_reg;
  assign word_valid_o  = word_valid_reg;
  assign err_o         = err_reg;
  assign digit_count_o = count_reg;

endmodule

// File: tb/tb_uart_hex_word_assembler.sv
// Table-driven bench for uart_hex_word_assembler; committed words are checked
// against a scoreboard queue filled when the terminating byte is driven.
module tb_uart_hex_word_assembler;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic [31:0] data_o;
  logic        word_valid_o;
  logic        err_o;
  logic [3:0]  digit_count_o;

  uart_hex_word_assembler #(.DW(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_valid_i    (rx_valid_i),
    .rx_data_i     (rx_data_i),
    .data_o        (data_o),
    .word_valid_o  (word_valid_o),
    .err_o         (err_o),
    .digit_count_o (digit_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [7:0]  b;
    logic [3:0]  cnt;
    logic        err;
    logic        commit;
    logic [31:0] word;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];
  logic [31:0] exp_data;
  int          checks = 0;
  int          passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic void add(input logic [7:0] b, input int cnt, input logic err,
                              input logic commit = 1'b0, input logic [31:0] word = 32'h0);
    vec_t v;
    v.valid = 1'b1; v.b = b; v.cnt = 4'(cnt); v.err = err; v.commit = commit; v.word = word;
    vecs.push_back(v);
  endfunction

  function automatic void idle(input int cnt, input logic err);
    vec_t v;
    v.valid = 1'b0; v.b = 8'h00; v.cnt = 4'(cnt); v.err = err; v.commit = 1'b0; v.word = 32'h0;
    vecs.push_back(v);
  endfunction

  // After each edge: counters/flags, held data, pulse presence, and scoreboard pop.
  task automatic check_after_edge(input int idx, input vec_t v);
    logic [31:0] w;
    check($sformatf("v%0d count", idx), 32'(digit_count_o), 32'(v.cnt));
    check($sformatf("v%0d err", idx), 32'(err_o), 32'(v.err));
    check($sformatf("v%0d word_valid", idx), 32'(word_valid_o), 32'(v.commit));
    if (word_valid_o) begin
      if (sb.size() == 0) check($sformatf("v%0d unexpected pulse", idx), 32'd1, 32'd0);
      else begin
        w = sb.pop_front();
        check($sformatf("v%0d committed word", idx), data_o, w);
      end
    end
    check($sformatf("v%0d data", idx), data_o, exp_data);
  endtask

  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    rx_valid_i = v.valid;
    rx_data_i  = v.b;
    if (v.commit) begin
      sb.push_back(v.word);
      exp_data = v.word;
    end
    @(posedge clk);
    #1;
    $display("vec %0d valid=%0b byte=%h -> data=%h wv=%0b err=%0b cnt=%0d",
             idx, v.valid, v.b, data_o, word_valid_o, err_o, digit_count_o);
    check_after_edge(idx, v);
  endtask

  initial begin
    reset = 1'b1; rx_valid_i = 1'b0; rx_data_i = 8'h00; exp_data = 32'h0;

    // 1: full word, then an idle cycle
    add("1",1,0); add("2",2,0); add("3",3,0); add("4",4,0);
    add("A",5,0); add("B",6,0); add("C",7,0); add("D",8,0);
    add(8'h0D,0,0,1,32'h1234ABCD); idle(0,0);
    // 2: lowercase, CR LF gives one commit
    add("f",1,0); add("f",2,0); add(8'h0D,0,0,1,32'h000000FF); add(8'h0A,0,0); idle(0,0);
    // 3: nine digits, oldest dropped, count saturates
    add("1",1,0); add("2",2,0); add("3",3,0); add("4",4,0); add("5",5,0);
    add("6",6,0); add("7",7,0); add("8",8,0); add("9",8,0);
    add(8'h0D,0,0,1,32'h23456789);
    add("f",1,0); add("f",2,0); add(8'h0D,0,0,1,32'h000000FF);
    // 4: error mid-word, recovery on CR, then a fresh word
    add("1",1,0); add("2",2,0); add("G",0,1); add("3",0,1); idle(0,1);
    add(8'h0D,0,0); add("7",1,0); add(8'h0D,0,0,1,32'h00000007);
    // 5: backspace, escape abort, backspace to empty
    add("A",1,0); add("B",2,0); add(8'h08,1,0); add("C",2,0); add(8'h0D,0,0,1,32'h000000AC);
    add("9",1,0); add("9",2,0); add(8'h1B,0,0); add(8'h0D,0,0);
    add("5",1,0); add(8'h08,0,0); add(8'h08,0,0); add(8'h0D,0,0);
    // spaces ignored; OTHER from IDLE enters ERROR, ESC leaves it
    add(8'h20,0,0); add("1",1,0); add(8'h20,1,0); add("2",2,0); add(8'h0D,0,0,1,32'h00000012);
    add("z",0,1); add(8'h0D,0,0); add("x",0,1); add("5",0,1); add(8'h1B,0,0);
    // all-ones word
    for (int i = 0; i < 8; i++) add((i % 2) ? "F" : "f", i + 1, 0);
    add(8'h0D,0,0,1,32'hFFFFFFFF);

    repeat (3) @(posedge clk);
    #1;
    check("reset data", data_o, 32'h0);
    check("reset word_valid", 32'(word_valid_o), 32'd0);
    check("reset err", 32'(err_o), 32'd0);
    check("reset count", 32'(digit_count_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // 6: reset mid-word while a byte is presented; reset wins
    @(negedge clk); rx_valid_i = 1'b1; rx_data_i = "1";
    @(negedge clk); rx_data_i = "2";
    @(negedge clk); rx_data_i = "4"; reset = 1'b1;
    @(posedge clk); #1;
    $display("reset-mid-word -> data=%h wv=%0b err=%0b cnt=%0d", data_o, word_valid_o, err_o, digit_count_o);
    check("midreset data", data_o, 32'h0);
    check("midreset err", 32'(err_o), 32'd0);
    check("midreset count", 32'(digit_count_o), 32'd0);
    check("midreset word_valid", 32'(word_valid_o), 32'd0);
    @(negedge clk); reset = 1'b0; rx_valid_i = 1'b0;
    exp_data = 32'h0;
    sb.delete();
    vecs.delete();
    add("3",1,0); add(8'h0D,0,0,1,32'h00000003); idle(0,0);
    for (int i = 0; i < vecs.size(); i++) apply(1000 + i, vecs[i]);

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
